freq_meter: RTL and testbench

//  Measures a slow, asynchronous clock-like input (e.g. the 10 Hz divided

---
 rtl/freq_meter.sv | 136 +++++++++++++
 tb/tb_freq_meter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Measures period and high time of a slow async input in clk_100MHz cycles; valid lands 3 edges after sig_in is first sampled high.
// No backpressure: valid is a 1-cycle pulse, results hold until the next measurement or a timeout.
module freq_meter #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 200_000_000,
    parameter int unsigned EXP_PERIOD  = 10_000_000,
    parameter int unsigned TOL         = 1_000
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_cycles,
    output logic [CNT_W-1:0] high_cycles,
    output logic             valid,
    output logic             in_range,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_TIMEOUT   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] L_IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] L_EXP       = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] L_TOL       = CNT_W'(TOL);

    typedef enum logic {ST_IDLE, ST_ARMED} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_s1, r_s2, r_s3;
    logic             r_rise, r_lvl;
    logic [CNT_W-1:0] r_cnt, r_hi_cnt, r_idle_cnt;
    logic [CNT_W-1:0] w_cnt_nxt, w_hi_nxt, w_idle_nxt;
    logic [CNT_W-1:0] w_period_nxt, w_high_nxt;
    logic             w_valid_nxt, w_in_range_nxt, w_locked_nxt, w_timeout_nxt;
    logic             w_rise;
    logic             w_cnt_in_tol;
    logic signed [CNT_W:0] w_diff, w_abs;

    // Extra stage after edge detect keeps rise and level aligned for the counters.
    assign w_rise = r_s2 & ~r_s3;

    assign w_diff       = $signed({1'b0, r_cnt}) - $signed({1'b0, L_EXP});
    assign w_abs        = (w_diff < 0) ? -w_diff : w_diff;
    assign w_cnt_in_tol = (w_abs <= $signed({1'b0, L_TOL}));

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_s3          <= 1'b0;
            r_rise        <= 1'b0;
            r_lvl         <= 1'b0;
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_hi_cnt      <= '0;
            r_idle_cnt    <= '0;
            period_cycles <= '0;
            high_cycles   <= '0;
            valid         <= 1'b0;
            in_range      <= 1'b0;
            locked        <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            r_s1          <= sig_in;
            r_s2          <= r_s1;
            r_s3          <= r_s2;
            r_rise        <= w_rise;
            r_lvl         <= r_s2;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_hi_cnt      <= w_hi_nxt;
            r_idle_cnt    <= w_idle_nxt;
            period_cycles <= w_period_nxt;
            high_cycles   <= w_high_nxt;
            valid         <= w_valid_nxt;
            in_range      <= w_in_range_nxt;
            locked        <= w_locked_nxt;
            timeout       <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hi_nxt       = r_hi_cnt;
        w_idle_nxt     = r_idle_cnt;
        w_period_nxt   = period_cycles;
        w_high_nxt     = high_cycles;
        w_valid_nxt    = 1'b0;
        w_in_range_nxt = in_range;
        w_locked_nxt   = locked;
        w_timeout_nxt  = timeout;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_hi_nxt  = '0;
                if (r_rise) begin
                    w_state_nxt = ST_ARMED;
                    w_cnt_nxt   = L_ONE;
                    w_hi_nxt    = L_ONE;
                    w_idle_nxt  = '0;
                end else if (r_idle_cnt == L_IDLE_LAST) begin
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_idle_nxt = r_idle_cnt + L_ONE;
                end
            end
            ST_ARMED: begin
                // A rise on the timeout cycle still counts as a measurement.
                if (r_rise) begin
                    w_period_nxt   = r_cnt;
                    w_high_nxt     = r_hi_cnt;
                    w_valid_nxt    = 1'b1;
                    w_locked_nxt   = 1'b1;
                    w_timeout_nxt  = 1'b0;
                    w_in_range_nxt = w_cnt_in_tol;
                    w_cnt_nxt      = L_ONE;
                    w_hi_nxt       = L_ONE;
                end else if (r_cnt == L_TIMEOUT) begin
                    w_state_nxt    = ST_IDLE;
                    w_timeout_nxt  = 1'b1;
                    w_locked_nxt   = 1'b0;
                    w_in_range_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_hi_nxt       = '0;
                    w_idle_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + L_ONE;
                    w_hi_nxt  = r_hi_cnt + {{(CNT_W-1){1'b0}}, r_lvl};
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with scaled parameters; expected measurements are queued
// at each stimulus rise and checked by a monitor whenever valid pulses.
module tb_freq_meter;

    localparam int CNT_W = 32;
    localparam int T     = 3000;
    localparam int EXP   = 200;
    localparam int TOL_P = 10;

    logic             clk_100MHz = 1'b0;
    logic             reset      = 1'b1;
    logic             sig_in     = 1'b0;
    logic [CNT_W-1:0] period_cycles, high_cycles;
    logic             valid, in_range, locked, timeout;

    freq_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(T), .EXP_PERIOD(EXP), .TOL(TOL_P)) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .sig_in        (sig_in),
        .period_cycles (period_cycles),
        .high_cycles   (high_cycles),
        .valid         (valid),
        .in_range      (in_range),
        .locked        (locked),
        .timeout       (timeout)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        int p;
        int h;
        bit r;
        int c;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   armed  = 1'b0;
    int   prev_p = 0;
    int   prev_h = 0;
    int   last_rise = 0;
    bit   prev_v = 1'b0;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit in_rng(input int p);
        int d;
        d = (p > EXP) ? p - EXP : EXP - p;
        return d <= TOL_P;
    endfunction

    // One stimulus period starting with a rise; the rise closes the previous period.
    task automatic pulse(input int p, input int h);
        exp_t e;
        if (armed) begin
            e.p = prev_p;
            e.h = prev_h;
            e.r = in_rng(prev_p);
            e.c = cyc + 1 + 3;
            q.push_back(e);
        end
        sig_in    = 1'b1;
        last_rise = cyc + 1;
        prev_p    = p;
        prev_h    = h;
        armed     = 1'b1;
        repeat (h) @(negedge clk_100MHz);
        sig_in = 1'b0;
        repeat (p - h) @(negedge clk_100MHz);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},   period_cycles, 0);
        check({tag, "_high"},     high_cycles,   0);
        check({tag, "_valid"},    valid,         0);
        check({tag, "_in_range"}, in_range,      0);
        check({tag, "_locked"},   locked,        0);
        check({tag, "_timeout"},  timeout,       0);
    endtask

    always @(negedge clk_100MHz) begin
        exp_t e;
        if (!reset && valid) begin
            check("valid_width", prev_v, 0);
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got period %0d high %0d, expected no valid (cycle %0d)",
                         period_cycles, high_cycles, cyc);
            end else begin
                e = q.pop_front();
                check("latency",  cyc,           e.c);
                check("period",   period_cycles, e.p);
                check("high",     high_cycles,   e.h);
                check("in_range", in_range,      e.r);
                check("locked",   locked,        1);
                check("timeout",  timeout,       0);
            end
        end
        prev_v = reset ? 1'b0 : valid;
    end

    initial begin
        int target;
        repeat (3) @(negedge clk_100MHz);
        check_all_zero("reset");
        reset = 1'b0;

        // Idle timeout: no rise at all after reset.
        repeat (T - 1) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check("idle_timeout_early", timeout, 0);
        @(negedge clk_100MHz);
        check("idle_timeout", timeout, 1);
        check("idle_locked",  locked,  0);

        // Nominal 50% wave, then 25% duty fast wave.
        repeat (4) pulse(200, 100);
        repeat (3) pulse(40, 10);

        // Tolerance edges and exact timeout-length period.
        pulse(209, 100);
        pulse(211, 100);
        pulse(200, 100);
        pulse(T, 50);
        pulse(200, 1);
        pulse(200, 100);

        // Hold low: timeout T cycles after the counter restart of the last rise.
        target = last_rise + 2 + T;
        while (cyc < target) @(negedge clk_100MHz);
        check("armed_timeout_early", timeout, 0);
        @(negedge clk_100MHz);
        check("armed_timeout",   timeout,       1);
        check("to_locked",       locked,        0);
        check("to_in_range",     in_range,      0);
        check("to_period_hold",  period_cycles, 200);
        check("to_high_hold",    high_cycles,   1);
        armed = 1'b0;
        repeat (5) @(negedge clk_100MHz);

        // Recovery: first rise silent, second measures.
        repeat (3) pulse(200, 100);

        // Reset partway through a period discards it.
        pulse(160, 100);
        reset = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        check_all_zero("midreset");
        reset = 1'b0;
        armed = 1'b0;
        repeat (3) pulse(200, 100);

        repeat (10) @(negedge clk_100MHz);
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
